fp_operand_loader: RTL and testbench

- Upstream input stage of the floating-point ALU core.
- Deserialises two 32-bit IEEE-754 single-precision operands from the 8-bit dedicated input bus, most-significant byte first: operand A, then operand B.
- Latches the opcode when the transfer starts.
- Presents {op_a, op_b, op_code} to the ALU core with a valid/ready handshake and holds them stable until the core accepts them.

---
 rtl/fp_operand_loader.sv | 126 ++++++++++++
 tb/tb_fp_operand_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fp_operand_loader.sv
`default_nettype none
// fp_operand_loader: deserialises two MSB-first operands and an opcode into a valid/ready bundle.
// Optional FP_OPERAND_CLASSIFY_EN adds registered IEEE-754 single-precision class codes.
module fp_operand_loader #(
  parameter int BYTE_W = 8,
  parameter int OP_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in,
  input  logic [1:0]        opcode,
  input  logic              start,
  input  logic              op_ready,
  output logic [OP_W-1:0]   op_a,
  output logic [OP_W-1:0]   op_b,
  output logic [1:0]        op_code,
  output logic              op_valid,
  output logic              busy,
  output logic [3:0]        state_out
`ifdef FP_OPERAND_CLASSIFY_EN
  ,
  output logic [2:0]        class_a,
  output logic [2:0]        class_b
`endif
);

  localparam int NBYTES = OP_W / BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_A = 2'd1;
  localparam logic [1:0] S_LOAD_B = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] slot;

  // Byte 0 lands in the most-significant slot.
  assign slot      = LAST - cnt;
  assign busy      = (state != S_IDLE);
  assign state_out = {2'b00, state};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_code  <= '0;
      op_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a[OP_W-1 -: BYTE_W] <= in;
            op_code                <= opcode;
            cnt                    <= CNT_W'(1);
            state                  <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          op_a[int'(slot)*BYTE_W +: BYTE_W] <= in;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_LOAD_B;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_LOAD_B: begin
          op_b[int'(slot)*BYTE_W +: BYTE_W] <= in;
          if (cnt == LAST) begin
            cnt      <= '0;
            op_valid <= 1'b1;
            state    <= S_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (op_valid && op_ready) begin
            op_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FP_OPERAND_CLASSIFY_EN
  localparam int EXP_W = 8;
  localparam int MAN_W = OP_W - 1 - EXP_W;

  // Sign bit is excluded from the argument; class does not depend on it.
  function automatic logic [2:0] classify(input logic [OP_W-2:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = x[OP_W-2 -: EXP_W];
    m = x[MAN_W-1:0];
    if (e == '0)
      classify = (m == '0) ? 3'd0 : 3'd1;
    else if (e == '1)
      classify = (m == '0) ? 3'd3 : (m[MAN_W-1] ? 3'd4 : 3'd5);
    else
      classify = 3'd2;
  endfunction

  logic [OP_W-1:0] b_final;
  assign b_final = {op_b[OP_W-1:BYTE_W], in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_a <= 3'd0;
      class_b <= 3'd0;
    end else if (state == S_LOAD_B && cnt == LAST) begin
      class_a <= classify(op_a[OP_W-2:0]);
      class_b <= classify(b_final[OP_W-2:0]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_operand_loader.sv
`default_nettype none
// Scoreboard bench for fp_operand_loader: driver queues expected bundles, monitor checks them.
module tb_fp_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in;
  logic [1:0]  opcode;
  logic        start;
  logic        op_ready;
  logic [31:0] op_a, op_b;
  logic [1:0]  op_code;
  logic        op_valid, busy;
  logic [3:0]  state_out;
`ifdef FP_OPERAND_CLASSIFY_EN
  logic [2:0]  class_a, class_b;
`endif

  fp_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .in(in), .opcode(opcode), .start(start),
    .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .op_valid(op_valid), .busy(busy), .state_out(state_out)
`ifdef FP_OPERAND_CLASSIFY_EN
    , .class_a(class_a), .class_b(class_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  c;
  } bundle_t;

  bundle_t expq[$];
  bundle_t cur;
  int n_pass = 0;
  int n_total = 0;
  int pulses = 0;
  logic seen_valid = 1'b0;
  logic acc_q = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= 1'b0;
    else        acc_q <= op_valid & op_ready;
  end

  // Monitor: pops on each new bundle, then checks hold stability and acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (op_valid && !seen_valid) begin
        pulses++;
        chk("bundle_expected", 128'(expq.size() != 0), 128'(1));
        if (expq.size() != 0) begin
          cur = expq.pop_front();
          chk("bundle", 128'({op_a, op_b, op_code}), 128'(cur));
          chk("hold_state", 128'({busy, state_out}), 128'({1'b1, 4'd3}));
        end
      end else if (op_valid) begin
        chk("hold_stable", 128'({op_a, op_b, op_code}), 128'(cur));
      end
      if (acc_q)
        chk("accept", 128'({op_valid, busy, state_out, op_a, op_b}),
            128'({1'b0, 1'b0, 4'd0, cur.a, cur.b}));
      seen_valid = op_valid;
    end else begin
      seen_valid = 1'b0;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] code,
                      input bit inject);
    logic [63:0] s;
    s = {a, b};
    expq.push_back({a, b, code});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) chk("in_load_a", 128'({busy, state_out}), 128'({1'b1, 4'd1}));
      if (i == 6) chk("in_load_b", 128'({busy, state_out}), 128'({1'b1, 4'd2}));
      start  = (i == 0) || (inject && i == 5);
      opcode = (i == 0) ? code : 2'b11;
      in     = s[63-8*i -: 8];
    end
    @(negedge clk);
    start = 1'b0;
    in    = 8'h00;
    chk("latency_valid", 128'(op_valid), 128'(1));
  endtask

  task automatic accept_once();
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst_n = 1'b0; start = 1'b0; in = 8'h00; opcode = 2'b00; op_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_vals", 128'({op_a, op_b, op_code, op_valid, busy, state_out}), 128'(0));
`ifdef FP_OPERAND_CLASSIFY_EN
    chk("reset_class", 128'({class_a, class_b}), 128'(0));
`endif
    rst_n = 1'b1;

    // Basic transfer held for five cycles, then a single-cycle accept.
    send(32'h3F800000, 32'h40000000, 2'b01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 128'(op_valid), 128'(1));
    end
    accept_once();
    chk("retain_a", 128'({op_valid, op_a}), 128'({1'b0, 32'h3F800000}));

    // start during LOAD_B is ignored; opcode stays as latched.
    send(32'h41200000, 32'hC1A00000, 2'b10, 1'b1);
    accept_once();

    // Reset after five bytes discards the partial transfer.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start  = (i == 0);
      opcode = 2'b01;
      in     = 8'hA0 + 8'(i);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 128'({op_a, op_b, op_code, op_valid, busy, state_out}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send(32'hC0490FDB, 32'h7F800000, 2'b00, 1'b0);
    accept_once();

    // op_ready tied high: two back-to-back bundles, each a one-cycle pulse.
    @(negedge clk);
    op_ready = 1'b1;
    p0 = pulses;
    send(32'h3F800000, 32'hBF800000, 2'b11, 1'b0);
    send(32'h00000000, 32'hFFFFFFFF, 2'b10, 1'b0);
    repeat (3) @(negedge clk);
    op_ready = 1'b0;
    chk("pulse_count", 128'(pulses - p0), 128'(2));

`ifdef FP_OPERAND_CLASSIFY_EN
    send(32'h00000001, 32'h7F800001, 2'b00, 1'b0);
    chk("class_sub_snan", 128'({class_a, class_b}), 128'({3'd1, 3'd5}));
    accept_once();
    send(32'h80000000, 32'h7FC00000, 2'b01, 1'b0);
    chk("class_zero_qnan", 128'({class_a, class_b}), 128'({3'd0, 3'd4}));
    accept_once();
`endif

    for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 128'(expq.size()), 128'(0));
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
